// File: rtl/output_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : output_write_arbiter_if
// Description : Bundles the two requester handshakes (A = CPU store path,
//               B = debug/loader path) and the registered write triple that
//               feeds the output-device register file.
//   slave  modport : arbiter side (accepts requests, drives write triple)
//   master modport : requester / device-file side
//   Signals: a_/b_ valid, ready, address, value; out_address, out_value,
//            out_is_write, busy, write_count
// Revision    : 1.0  initial release
// ============================================================================
interface output_write_arbiter_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   a_valid;
  logic                   a_ready;
  logic [ADDR_WIDTH-1:0]  a_address;
  logic [DATA_WIDTH-1:0]  a_value;
  logic                   b_valid;
  logic                   b_ready;
  logic [ADDR_WIDTH-1:0]  b_address;
  logic [DATA_WIDTH-1:0]  b_value;
  logic [ADDR_WIDTH-1:0]  out_address;
  logic [DATA_WIDTH-1:0]  out_value;
  logic                   out_is_write;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] write_count;

  modport slave (
    input  a_valid, a_address, a_value,
    input  b_valid, b_address, b_value,
    output a_ready, b_ready,
    output out_address, out_value, out_is_write, busy, write_count
  );

  modport master (
    output a_valid, a_address, a_value,
    output b_valid, b_address, b_value,
    input  a_ready, b_ready,
    input  out_address, out_value, out_is_write, busy, write_count
  );
endinterface
`default_nettype wire

// File: rtl/output_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_write_arbiter
// Description : Round-robin sharing of the device register file write port
//               between port A and port B. Each port owns a one-entry holding
//               register; one write is issued per cycle as a registered
//               address/value/is_write triple that the device file samples on
//               the following negedge.
//   clk   : system clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : output_write_arbiter_if.slave (handshakes + write triple)
// Revision    : 1.0  initial release
// ============================================================================
module output_write_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input wire logic              clk,
  input wire logic              reset,
  output_write_arbiter_if.slave bus
);

  // Which port received the most recent grant; the other one wins a tie.
  typedef enum logic [0:0] {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  last_t                  r_last;
  last_t                  w_last_next;

  logic                   r_hold_a_full;
  logic [ADDR_WIDTH-1:0]  r_hold_a_addr;
  logic [DATA_WIDTH-1:0]  r_hold_a_val;
  logic                   r_hold_b_full;
  logic [ADDR_WIDTH-1:0]  r_hold_b_addr;
  logic [DATA_WIDTH-1:0]  r_hold_b_val;

  logic [ADDR_WIDTH-1:0]  r_out_addr;
  logic [DATA_WIDTH-1:0]  r_out_val;
  logic                   r_out_wr;
  logic [COUNT_WIDTH-1:0] r_count;

  logic                   w_grant_a;
  logic                   w_grant_b;
  logic                   w_ready_a;
  logic                   w_ready_b;
  logic                   w_acc_a;
  logic                   w_acc_b;

  // Grant decision and round-robin pointer update.
  always_comb begin
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_last_next = r_last;
    if (r_hold_a_full && r_hold_b_full) begin
      w_grant_a = (r_last == LAST_B);
      w_grant_b = (r_last == LAST_A);
    end else begin
      w_grant_a = r_hold_a_full;
      w_grant_b = r_hold_b_full;
    end
    if (w_grant_a) begin
      w_last_next = LAST_A;
    end else if (w_grant_b) begin
      w_last_next = LAST_B;
    end
  end

  // A hold that drains this cycle can take a new request in the same cycle,
  // which is what allows one port to stream at one write per cycle.
  assign w_ready_a = !r_hold_a_full || w_grant_a;
  assign w_ready_b = !r_hold_b_full || w_grant_b;
  assign w_acc_a   = bus.a_valid && w_ready_a;
  assign w_acc_b   = bus.b_valid && w_ready_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= LAST_B;
    end else begin
      r_last <= w_last_next;
    end
  end

  // Holding registers: a refill takes priority over the drain-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_a_full <= 1'b0;
      r_hold_a_addr <= '0;
      r_hold_a_val  <= '0;
      r_hold_b_full <= 1'b0;
      r_hold_b_addr <= '0;
      r_hold_b_val  <= '0;
    end else begin
      if (w_acc_a) begin
        r_hold_a_full <= 1'b1;
        r_hold_a_addr <= bus.a_address;
        r_hold_a_val  <= bus.a_value;
      end else if (w_grant_a) begin
        r_hold_a_full <= 1'b0;
      end
      if (w_acc_b) begin
        r_hold_b_full <= 1'b1;
        r_hold_b_addr <= bus.b_address;
        r_hold_b_val  <= bus.b_value;
      end else if (w_grant_b) begin
        r_hold_b_full <= 1'b0;
      end
    end
  end

  // Registered write triple; address/value hold their last value when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_addr <= '0;
      r_out_val  <= '0;
      r_out_wr   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_out_wr <= w_grant_a || w_grant_b;
      if (w_grant_a) begin
        r_out_addr <= r_hold_a_addr;
        r_out_val  <= r_hold_a_val;
        r_count    <= r_count + 1'b1;
      end else if (w_grant_b) begin
        r_out_addr <= r_hold_b_addr;
        r_out_val  <= r_hold_b_val;
        r_count    <= r_count + 1'b1;
      end
    end
  end

  assign bus.a_ready      = w_ready_a;
  assign bus.b_ready      = w_ready_b;
  assign bus.out_address  = r_out_addr;
  assign bus.out_value    = r_out_val;
  assign bus.out_is_write = r_out_wr;
  assign bus.write_count  = r_count;
  assign bus.busy         = r_hold_a_full || r_hold_b_full || r_out_wr;

endmodule
`default_nettype wire

// File: tb/tb_output_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_write_arbiter
// Description : Self-checking bench for output_write_arbiter. A transaction
//               level model (per-port pending queues, round-robin pick, device
//               memory) predicts readies, the write triple, busy and the
//               counter. Directed scenarios plus a randomized phase.
// Revision    : 1.0  initial release
// ============================================================================
module tb_output_write_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
  } req_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  output_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) ifc ();

  output_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  req_t          qa[$];
  req_t          qb[$];
  bit            last_was_b;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_val;
  logic          m_wr;
  logic [CW-1:0] m_cnt;
  logic [DW-1:0] mem_m   [int];
  logic [DW-1:0] dut_mem [int];
  int            dut_wr_cnt = 0;
  bit            last_ra, last_rb;

  // Device register file: commits the triple on the negedge.
  always @(negedge clk) begin
    if (ifc.out_is_write) begin
      dut_mem[int'(ifc.out_address)] = ifc.out_value;
      dut_wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = nobody pending, 1 = A served next, 2 = B served next
  function automatic int pick();
    if (qa.size() != 0 && qb.size() != 0) return last_was_b ? 1 : 2;
    if (qa.size() != 0) return 1;
    if (qb.size() != 0) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    last_was_b = 1'b1;
    m_addr = '0;
    m_val  = '0;
    m_wr   = 1'b0;
    m_cnt  = '0;
  endtask

  // Called just after a posedge: drives inputs for one cycle and checks it.
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    int   g;
    bit   ra, rb;
    req_t r;
    ifc.a_valid = av; ifc.a_address = aa; ifc.a_value = ad;
    ifc.b_valid = bv; ifc.b_address = ba; ifc.b_value = bd;
    @(negedge clk);
    g  = pick();
    ra = (qa.size() == 0) || (g == 1);
    rb = (qb.size() == 0) || (g == 2);
    check("a_ready", 64'(ifc.a_ready), 64'(ra));
    check("b_ready", 64'(ifc.b_ready), 64'(rb));
    last_ra = ra;
    last_rb = rb;
    @(posedge clk);
    m_wr = 1'b0;
    if (g != 0) begin
      r = (g == 1) ? qa.pop_front() : qb.pop_front();
      m_addr = r.addr;
      m_val  = r.val;
      m_wr   = 1'b1;
      m_cnt  = m_cnt + 1'b1;
      last_was_b = (g == 2);
      mem_m[int'(r.addr)] = r.val;
    end
    if (av && ra) qa.push_back('{aa, ad});
    if (bv && rb) qb.push_back('{ba, bd});
    #1;
    check("out_is_write", 64'(ifc.out_is_write), 64'(m_wr));
    check("out_address",  64'(ifc.out_address),  64'(m_addr));
    check("out_value",    64'(ifc.out_value),    64'(m_val));
    check("write_count",  64'(ifc.write_count),  64'(m_cnt));
    check("busy", 64'(ifc.busy), 64'(qa.size() != 0 || qb.size() != 0 || m_wr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  // Asserts reset asynchronously between edges; checks the reset state and
  // that no device write occurs at the next negedge. Ends just after a posedge.
  task automatic do_reset();
    int snap;
    ifc.a_valid = 1'b0;
    ifc.b_valid = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_out_is_write", 64'(ifc.out_is_write), 64'd0);
    check("rst_out_address",  64'(ifc.out_address),  64'd0);
    check("rst_out_value",    64'(ifc.out_value),    64'd0);
    check("rst_write_count",  64'(ifc.write_count),  64'd0);
    check("rst_busy",         64'(ifc.busy),         64'd0);
    snap = dut_wr_cnt;
    @(negedge clk);
    #1;
    check("rst_no_dev_write", 64'(dut_wr_cnt), 64'(snap));
    reset = 1'b0;
    check("rst_a_ready", 64'(ifc.a_ready), 64'd1);
    check("rst_b_ready", 64'(ifc.b_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            av, bv;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd;

    ifc.a_valid = 1'b0; ifc.a_address = '0; ifc.a_value = '0;
    ifc.b_valid = 1'b0; ifc.b_address = '0; ifc.b_value = '0;
    model_reset();
    do_reset();

    // 1: single write from A
    idle(1);
    step(1, 16'd0, 32'hDEADBEEF, 0, '0, '0);
    step(0, '0, '0, 0, '0, '0);
    check("t1_out_value", 64'(ifc.out_value), 64'h0000_0000_DEAD_BEEF);
    check("t1_count", 64'(ifc.write_count), 64'd1);
    idle(1);
    check("t1_busy_low", 64'(ifc.busy), 64'd0);
    check("t1_mem0", 64'(dut_mem[0]), 64'h0000_0000_DEAD_BEEF);

    // 2: same address from both ports in the same cycle
    do_reset();
    step(1, 16'd1, 32'h11, 1, 16'd1, 32'h22);
    idle(3);
    check("t2_mem1", 64'(dut_mem[1]), 64'h22);
    check("t2_count", 64'(ifc.write_count), 64'd2);

    // 3: both ports valid continuously -> alternating grants
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'(10 + i), 32'(100 + i), 1, 16'(20 + i), 32'(200 + i));
    idle(4);
    check("t3_count", 64'(ifc.write_count), 64'(m_cnt));

    // 4: A streams addr 0 values 1..5 with B idle
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1, 16'd0, 32'(i), 0, '0, '0);
      check("t4_a_ready", 64'(last_ra), 64'd1);
    end
    idle(3);
    check("t4_mem0", 64'(dut_mem[0]), 64'd5);
    check("t4_count", 64'(ifc.write_count), 64'd5);

    // 5: counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) step(1, 16'(i), 32'(i), 0, '0, '0);
    idle(2);
    check("t5_count_ffff", 64'(ifc.write_count), 64'hFFFF);
    step(1, 16'd3, 32'h5, 0, '0, '0);
    idle(2);
    check("t5_count_wrap", 64'(ifc.write_count), 64'd0);

    // 6: reset while both holds full and a write is on the wire
    do_reset();
    step(1, 16'd7, 32'hA1, 1, 16'd8, 32'hB1);
    step(1, 16'd7, 32'hA2, 1, 16'd8, 32'hB1);
    check("t6_pre_wr", 64'(ifc.out_is_write), 64'd1);
    do_reset();
    idle(2);

    // Randomized phase; a stalled request keeps address/value stable.
    av = 0; bv = 0; aa = '0; ba = '0; ad = '0; bd = '0;
    last_ra = 1; last_rb = 1;
    for (int i = 0; i < 400; i++) begin
      if (!(av && !last_ra)) begin
        av = ($urandom_range(0, 3) != 0);
        aa = 16'($urandom_range(0, 3));
        ad = $urandom;
      end
      if (!(bv && !last_rb)) begin
        bv = ($urandom_range(0, 2) != 0);
        ba = 16'($urandom_range(0, 3));
        bd = $urandom;
      end
      step(av, aa, ad, bv, ba, bd);
    end
    idle(3);
    for (int k = 0; k < 4; k++) begin
      if (mem_m.exists(k)) check("rand_mem", 64'(dut_mem[k]), 64'(mem_m[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
